fp32_multiplication: RTL and testbench

- Single-precision IEEE-754 (binary32) multiplier with a registered output.
- Computes `out = inA * inB` combinationally, including special-value handling, and captures the result on the rising clock edge.
- Used as the multiply unit of the floating-point module alongside the adder/divider blocks.

---
 rtl/fp32_multiplication.sv | 111 +++++++++++
 tb/tb_fp32_multiplication.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fp32_multiplication.sv
// fp32_multiplication: IEEE-754 binary32 multiplier with a single registered
// output stage. Subnormal operands are flushed to signed zero, results that
// fall below the normal range flush to signed zero, and every NaN outcome is
// the canonical quiet NaN 32'h7FC0_0000. Rounding is round-to-nearest-even.
module fp32_multiplication (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    output logic [31:0] out
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Exponent field of zero: true zeros and subnormals (flushed).
    function automatic logic is_zero(input logic [31:0] x);
        return (x[30:23] == 8'h00);
    endfunction

    // All-ones exponent with empty fraction.
    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'h000000);
    endfunction

    // All-ones exponent with any fraction payload.
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'h000000);
    endfunction

    logic               sign_s;
    logic [23:0]        sig_a_s;
    logic [23:0]        sig_b_s;
    logic [47:0]        prod_s;
    logic [47:0]        norm_s;
    logic signed [9:0]  exp_s;
    logic [23:0]        sig_keep_s;
    logic               guard_s;
    logic               round_s;
    logic               sticky_s;
    logic               round_up_s;
    logic [24:0]        sum_s;
    logic [22:0]        frac_s;
    logic signed [9:0]  exp_fin_s;
    logic [31:0]        result_s;

    // Datapath: significand product, normalization and round-to-nearest-even.
    always_comb begin
        sign_s     = inA[31] ^ inB[31];
        sig_a_s    = {1'b1, inA[22:0]};
        sig_b_s    = {1'b1, inB[22:0]};
        prod_s     = {24'h000000, sig_a_s} * {24'h000000, sig_b_s};
        norm_s     = prod_s;
        exp_s      = $signed({2'b00, inA[30:23]}) + $signed({2'b00, inB[30:23]}) - 10'sd127;
        frac_s     = 23'h000000;
        exp_fin_s  = 10'sd0;

        // Product of two [1,2) significands lies in [1,4); bit 47 marks [2,4).
        if (prod_s[47]) begin
            norm_s = prod_s;
            exp_s  = exp_s + 10'sd1;
        end else begin
            norm_s = {prod_s[46:0], 1'b0};
        end

        sig_keep_s = norm_s[47:24];
        guard_s    = norm_s[23];
        round_s    = norm_s[22];
        sticky_s   = |norm_s[21:0];
        round_up_s = guard_s & (round_s | sticky_s | sig_keep_s[0]);
        sum_s      = {1'b0, sig_keep_s} + {24'h000000, round_up_s};

        // A carry out of rounding leaves 1.000...; renormalize by one place.
        if (sum_s[24]) begin
            frac_s    = sum_s[23:1];
            exp_fin_s = exp_s + 10'sd1;
        end else begin
            frac_s    = sum_s[22:0];
            exp_fin_s = exp_s;
        end
    end

    // Result selection: special operands by priority, then range limits.
    always_comb begin
        result_s = 32'h0000_0000;
        if (is_nan(inA) || is_nan(inB)) begin
            result_s = QNAN;
        end else if ((is_zero(inA) && is_inf(inB)) || (is_inf(inA) && is_zero(inB))) begin
            result_s = QNAN;
        end else if (is_inf(inA) || is_inf(inB)) begin
            result_s = {sign_s, 8'hFF, 23'h000000};
        end else if (is_zero(inA) || is_zero(inB)) begin
            result_s = {sign_s, 31'h0000_0000};
        end else if (exp_fin_s >= 10'sd255) begin
            result_s = {sign_s, 8'hFF, 23'h000000};
        end else if (exp_fin_s <= 10'sd0) begin
            result_s = {sign_s, 31'h0000_0000};
        end else begin
            result_s = {sign_s, exp_fin_s[7:0], frac_s};
        end
    end

    // Output register; reset clears any pending product immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= 32'h0000_0000;
        end else begin
            out <= result_s;
        end
    end

endmodule

// File: tb/tb_fp32_multiplication.sv
// Directed bench for fp32_multiplication: literal expectations per vector plus
// a real-arithmetic reference model compared against the output every cycle.
module tb_fp32_multiplication;

    logic        clk;
    logic        rst_n;
    logic [31:0] inA;
    logic [31:0] inB;
    logic [31:0] out;

    int tests;
    int fails;
    logic        chk_en;
    logic [31:0] exp_q;

    localparam logic [31:0] P15  = 32'h3FC0_0000;
    localparam logic [31:0] P92  = 32'h42B9_5C29;
    localparam logic [31:0] PINF = 32'h7F80_0000;
    localparam logic [31:0] NAN1 = 32'h7FAA_AAAA;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    fp32_multiplication dut (
        .clk   (clk),
        .rst_n (rst_n),
        .inA   (inA),
        .inB   (inB),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real pow2(input int k);
        real p;
        p = 1.0;
        if (k >= 0) begin
            for (int i = 0; i < k; i++) p = p * 2.0;
        end else begin
            for (int i = 0; i < -k; i++) p = p / 2.0;
        end
        return p;
    endfunction

    // Reference: exact real product of integer significands, then RNE to 24 bits.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int   ea, eb, n, e, biased;
        logic az, bz, ai, bi, an, bn;
        real  x, m, fl, fr;
        longint f;
        logic [31:0] r;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 23'd0);
        bi = (eb == 255) && (b[22:0] == 23'd0);
        an = (ea == 255) && (a[22:0] != 23'd0);
        bn = (eb == 255) && (b[22:0] != 23'd0);
        if (an || bn) return QNAN;
        if ((az && bi) || (ai && bz)) return QNAN;
        if (ai || bi) return {s, 31'h7F80_0000};
        if (az || bz) return {s, 31'h0};
        x = (8388608.0 + real'(a[22:0])) * (8388608.0 + real'(b[22:0]));
        n = 46;
        if (x >= pow2(47)) n = 47;
        m  = x / pow2(n - 23);
        fl = $floor(m);
        fr = m - fl;
        f  = longint'(fl);
        if (fr > 0.5 || (fr == 0.5 && f[0])) f = f + 64'sd1;
        e = n + ea + eb - 300;
        if (f == 64'sd16777216) begin
            f = 64'sd8388608;
            e = e + 1;
        end
        biased = e + 127;
        if (biased >= 255) return {s, 31'h7F80_0000};
        if (biased <= 0) return {s, 31'h0};
        r = {s, 8'(biased), 23'(f - 64'sd8388608)};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    // Drive one operand pair; check the registered result just after the edge.
    task automatic apply(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] req);
        @(negedge clk);
        inA = a;
        inB = b;
        check({name, "_model"}, model(a, b), req);
        @(posedge clk);
        #1;
        check(name, out, req);
    endtask

    // Expected output tracks the reference one edge behind the operands.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= 32'h0;
        else        exp_q <= model(inA, inB);
    end

    // Cycle compare of DUT against the reference model.
    always @(negedge clk) begin
        if (chk_en) check("cycle", out, exp_q);
    end

    initial begin
        logic [31:0] sa, sb, pa, pb, za, zb;
        tests  = 0;
        fails  = 0;
        chk_en = 1'b0;
        rst_n  = 1'b1;
        inA    = 32'h0;
        inB    = 32'h0;
        #1 rst_n = 1'b0;
        #2 check("reset_out", out, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        check("reset_hold", out, 32'h0);
        chk_en = 1'b1;

        // Sign permutations of 1.5 x 92.68.
        for (int i = 0; i < 4; i++) begin
            sa = {i[1], 31'h0};
            sb = {i[0], 31'h0};
            apply("normal", P15 | sa, P92 | sb, {i[1] ^ i[0], 31'h430B_051F});
        end
        apply("neg_a", 32'hBFC0_0000, P92, 32'hC30B_051F);

        // Zeros, 16 combinations.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 4; i++) begin
                za = (p == 1) ? P15 : ((p == 2) ? P92 : 32'h0);
                zb = (p == 3) ? P92 : 32'h0;
                za = za | {i[1], 31'h0};
                zb = zb | {i[0], 31'h0};
                apply("zero", za, zb, {i[1] ^ i[0], 31'h0});
            end
        end
        apply("zero_ex1", 32'h8000_0000, 32'hC2B9_5C29, 32'h0000_0000);
        apply("zero_ex2", P15, 32'h8000_0000, 32'h8000_0000);

        // Infinities.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) begin
                pa = (p == 1) ? P15 : PINF;
                pb = (p == 0) ? P92 : PINF;
                apply("inf", pa | {i[1], 31'h0}, pb | {i[0], 31'h0}, {i[1] ^ i[0], 31'h7F80_0000});
            end
        end
        apply("inf_ex", 32'hFF80_0000, PINF, 32'hFF80_0000);

        // NaN in either position, and zero x inf crossovers.
        apply("nan_15",   NAN1, P15, QNAN);
        apply("nan_92",   NAN1, P92, QNAN);
        apply("nan_m92",  32'hC2B9_5C29, NAN1, QNAN);
        apply("nan_nan",  NAN1, NAN1, QNAN);
        apply("nan_z",    NAN1, 32'h0, QNAN);
        apply("nan_mz",   32'h8000_0000, NAN1, QNAN);
        apply("nan_inf",  NAN1, PINF, QNAN);
        apply("nan_minf", 32'hFF80_0000, NAN1, QNAN);
        for (int i = 0; i < 4; i++) begin
            apply("z_inf", {i[1], 31'h0}, PINF | {i[0], 31'h0}, QNAN);
            apply("inf_z", PINF | {i[1], 31'h0}, {i[0], 31'h0}, QNAN);
        end

        // Range limits and rounding.
        apply("overflow",  32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000);
        apply("underflow", 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000);
        apply("subnormal", 32'h0000_0001, P15, 32'h0000_0000);
        apply("two_three", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        apply("rnd_sticky", 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
        apply("tie_up",    32'h3F80_0001, P15, 32'h3FC0_0002);
        apply("exact",     32'h3F80_0002, P15, 32'h3FC0_0003);
        apply("tie_down",  32'h3F80_0003, P15, 32'h3FC0_0004);
        apply("near_two",  32'h3FFF_FFFF, 32'h3F80_0001, 32'h4000_0000);

        // Asynchronous reset between edges while the output is nonzero.
        @(negedge clk);
        inA = P15;
        inB = P92;
        @(posedge clk);
        #1 check("pre_reset", out, 32'h430B_051F);
        #1 rst_n = 1'b0;
        #1 check("async_reset", out, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check("post_reset_hold", out, 32'h0);
        @(posedge clk);
        #1 check("post_reset_first", out, 32'h430B_051F);

        apply("b2b_1", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        apply("b2b_2", P15, P15, 32'h4010_0000);
        apply("b2b_3", 32'hC000_0000, 32'h4000_0000, 32'hC080_0000);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
